// File: rtl/div_seq.sv
// Iterative 32-bit restoring divider for div/divu, one quotient bit per cycle.
// Define DIV_SIGNED_EN to compile in signed operand handling and result sign fixup.
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    input  logic        i_annul,
    output logic        o_busy,
    output logic        o_ready,
    output logic [63:0] o_result
);

    typedef enum logic [1:0] {StIdle, StByzero, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [32:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvsr_q;
    logic [63:0] result_q;

    logic        accept;
    logic [31:0] mag_dvd, mag_dvs;
    logic [32:0] shifted;
    logic [33:0] trial;
    logic [32:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] quo_fix, rem_fix;

    assign accept = i_start & ~i_annul;

`ifdef DIV_SIGNED_EN
    logic neg_dvd, neg_dvs;
    logic sgn_dvd_q, sgn_dvs_q;

    assign neg_dvd = i_signed & i_dividend[31];
    assign neg_dvs = i_signed & i_divisor[31];
    assign mag_dvd = neg_dvd ? (~i_dividend + 32'd1) : i_dividend;
    assign mag_dvs = neg_dvs ? (~i_divisor + 32'd1) : i_divisor;
    // 0x80000000 / -1 wraps naturally: magnitude quotient 2^31 negates to itself.
    assign quo_fix = (sgn_dvd_q ^ sgn_dvs_q) ? (~quo_next + 32'd1) : quo_next;
    assign rem_fix = sgn_dvd_q ? (~rem_next[31:0] + 32'd1) : rem_next[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            sgn_dvd_q <= 1'b0;
            sgn_dvs_q <= 1'b0;
        end else if (state_q == StIdle && accept) begin
            sgn_dvd_q <= neg_dvd;
            sgn_dvs_q <= neg_dvs;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = i_signed;
    assign mag_dvd       = i_dividend;
    assign mag_dvs       = i_divisor;
    assign quo_fix       = quo_next;
    assign rem_fix       = rem_next[31:0];
`endif

    // One restoring step: shift {rem, quo} left, keep the trial if it did not borrow.
    assign shifted  = {rem_q[31:0], quo_q[31]};
    assign trial    = {1'b0, shifted} - {2'b00, dvsr_q};
    assign rem_next = trial[33] ? shifted : trial[32:0];
    assign quo_next = {quo_q[30:0], ~trial[33]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (i_divisor == 32'd0) ? StByzero : StRun;
                end
            end
            StByzero: state_d = i_annul ? StIdle : StDone;
            StRun: begin
                if (i_annul) begin
                    state_d = StIdle;
                end else if (cnt_q == 5'd31) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (i_annul || !i_start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_busy  = (state_q == StByzero) || (state_q == StRun);
        o_ready = (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 5'd0;
            rem_q    <= 33'd0;
            quo_q    <= 32'd0;
            dvsr_q   <= 32'd0;
            result_q <= 64'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    result_q <= 64'd0;
                    if (accept && i_divisor != 32'd0) begin
                        cnt_q  <= 5'd0;
                        rem_q  <= 33'd0;
                        quo_q  <= mag_dvd;
                        dvsr_q <= mag_dvs;
                    end
                end
                StByzero: result_q <= 64'd0;
                StRun: begin
                    if (!i_annul) begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            result_q <= {rem_fix, quo_fix};
                        end
                    end
                end
                StDone: begin
                    if (i_annul || !i_start) begin
                        result_q <= 64'd0;
                    end
                end
                default: result_q <= 64'd0;
            endcase
        end
    end

    assign o_result = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: cycle-level behavioural model plus directed vectors
// with hand-computed literal results and latencies.
module tb_div_seq;

`ifdef DIV_SIGNED_EN
    localparam bit SignedEn = 1'b1;
`else
    localparam bit SignedEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_signed = 1'b0;
    logic        i_annul = 1'b0;
    logic [31:0] i_dividend = 32'd0;
    logic [31:0] i_divisor = 32'd0;
    logic        o_busy, o_ready;
    logic [63:0] o_result;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    div_seq dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_signed   (i_signed),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .i_annul    (i_annul),
        .o_busy     (o_busy),
        .o_ready    (o_ready),
        .o_result   (o_result)
    );

    always #5 clk = ~clk;

    // Reference result from plain arithmetic; 64-bit math sidesteps the INT_MIN / -1 overflow.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input bit sgn);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: idle / counting down / holding a result.
    bit          m_busy = 1'b0;
    bit          m_ready = 1'b0;
    int          m_left = 0;
    logic [63:0] m_exp = 64'd0;
    logic [63:0] m_res = 64'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_ready = 1'b0;
            m_left  = 0;
            m_res   = 64'd0;
        end else if (m_ready) begin
            if (i_annul || !i_start) begin
                m_ready = 1'b0;
                m_res   = 64'd0;
            end
        end else if (m_busy) begin
            if (i_annul) begin
                m_busy = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy  = 1'b0;
                    m_ready = 1'b1;
                    m_res   = m_exp;
                end
            end
        end else if (i_start && !i_annul) begin
            m_busy = 1'b1;
            m_left = (i_divisor == 32'd0) ? 1 : 32;
            m_exp  = ref_div(i_dividend, i_divisor, SignedEn && i_signed);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {63'd0, o_busy}, {63'd0, m_busy});
            check("ready", {63'd0, o_ready}, {63'd0, m_ready});
            check("result", o_result, m_res);
            check("busy_ready_exclusive", {63'd0, o_busy & o_ready}, 64'd0);
        end
    end

    task automatic wait_ready(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!o_ready && k < 40);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int lat, input logic [63:0] lit, input bit use_lit);
        int k;
        @(negedge clk);
        i_start    = 1'b1;
        i_signed   = sgn;
        i_dividend = a;
        i_divisor  = b;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 3) begin
                i_dividend = ~a;
                i_divisor  = b + 32'd3;
            end
        end while (!o_ready && k < 40);
        check("latency", 64'(k), 64'(lat));
        if (use_lit) check("literal_result", o_result, lit);
        repeat (2) @(negedge clk);
        check("held_ready", {63'd0, o_ready}, 64'd1);
        i_start = 1'b0;
        @(negedge clk);
        check("released_ready", {63'd0, o_ready}, 64'd0);
        check("released_result", o_result, 64'd0);
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        check("reset_busy", {63'd0, o_busy}, 64'd0);
        check("reset_ready", {63'd0, o_ready}, 64'd0);
        check("reset_result", o_result, 64'd0);

        do_op(32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14}, 1'b1);
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 33, {32'd0, 32'hFFFF_FFFF}, 1'b1);
        do_op(32'd1234, 32'd0, 1'b0, 2, 64'd0, 1'b1);
        do_op(32'd5, 32'd9, 1'b0, 33, {32'd5, 32'd0}, 1'b1);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, {32'd0, 32'd1}, 1'b1);
        do_op(32'h1234_5678, 32'h0000_1234, 1'b0, 33, 64'd0, 1'b0);
`ifdef DIV_SIGNED_EN
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, {32'd0, 32'h8000_0000}, 1'b1);
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 33, {32'd1, 32'hFFFF_FFFD}, 1'b1);
        do_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 33, {32'hFFFF_FFFF, 32'd3}, 1'b1);
`else
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 33, {32'd1, 32'h7FFF_FFFC}, 1'b1);
`endif
        do_op(32'h8000_0000, 32'd0, 1'b1, 2, 64'd0, 1'b1);

        // Annul at cycle 10 of RUN, then a fresh request.
        @(negedge clk);
        i_start = 1'b1; i_signed = 1'b0; i_dividend = 32'd100; i_divisor = 32'd7;
        repeat (11) @(negedge clk);
        i_annul = 1'b1; i_start = 1'b0;
        @(negedge clk);
        check("annul_run_busy", {63'd0, o_busy}, 64'd0);
        check("annul_run_ready", {63'd0, o_ready}, 64'd0);
        i_annul = 1'b0;
        repeat (3) @(negedge clk);
        do_op(32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14}, 1'b1);

        // Start and annul together in IDLE: annul wins.
        i_start = 1'b1; i_annul = 1'b1; i_dividend = 32'd9; i_divisor = 32'd3;
        @(negedge clk);
        check("annul_idle_busy", {63'd0, o_busy}, 64'd0);
        i_start = 1'b0; i_annul = 1'b0;
        @(negedge clk);

        // Annul while holding the result.
        i_start = 1'b1; i_dividend = 32'd9; i_divisor = 32'd3;
        wait_ready(k);
        check("annul_done_latency", 64'(k), 64'd33);
        check("annul_done_result", o_result, {32'd0, 32'd3});
        i_annul = 1'b1;
        @(negedge clk);
        check("annul_done_ready", {63'd0, o_ready}, 64'd0);
        i_start = 1'b0; i_annul = 1'b0;
        @(negedge clk);

        // Reset at cycle 20 of RUN, then a new request must not see stale state.
        i_start = 1'b1; i_dividend = 32'hDEAD_BEEF; i_divisor = 32'h0000_1234;
        repeat (21) @(negedge clk);
        rst = 1'b1; i_start = 1'b0;
        @(negedge clk);
        check("rst_busy", {63'd0, o_busy}, 64'd0);
        check("rst_ready", {63'd0, o_ready}, 64'd0);
        check("rst_result", o_result, 64'd0);
        rst = 1'b0;
        do_op(32'd100, 32'd7, 1'b0, 33, {32'd2, 32'd14}, 1'b1);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
